calendar_day_counter: RTL and testbench

- Sequential month/day counter that advances one day per enable pulse, starting at 1/1.
- Rolls the day over at the end of each month. Month length comes from an internal 31-day-month ("big month") decode.
- Produces the 4-bit month value consumed by the big-month decoder stage, plus day, rollover strobes and a load/preset port for setting the date.

---
 rtl/calendar_day_counter.sv | 129 ++++++++++++
 tb/tb_calendar_day_counter.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/calendar_day_counter.sv
// rtl/calendar_day_counter.sv - month/day calendar counter with load, rollover strobes and optional leap input
//
// Purpose:
//   Advances a month/day date by one day per tick, starting at 1/1 after
//   reset. Month length comes from the big-month (31-day) decode, with
//   February taking FEB_DAYS days (or 29 when the leap input is set in
//   CAL_LEAP_EN builds). A load port presets the date, clamping the day to
//   the target month's length and rejecting illegal months.
//
// Configuration:
//   CAL_LEAP_EN - when defined, adds the leap input; leap=1 forces a
//                 29-day February for both ticking and load clamping.
//
// Ports:
//   clk        in   1  system clock, rising edge
//   rst        in   1  synchronous active-high reset
//   tick       in   1  advance one day this cycle
//   load       in   1  preset request using load_month/load_day
//   load_month in   4  preset month, legal 1..12
//   load_day   in   5  preset day, clamped to 1..month length
//   leap       in   1  (CAL_LEAP_EN only) force 29-day February
//   month      out  4  current month 1..12
//   day        out  5  current day 1..31
//   big_month  out  1  current month has 31 days (combinational)
//   month_end  out  1  one-cycle strobe after a month rollover
//   year_end   out  1  one-cycle strobe after a 12/31 -> 1/1 rollover
//   load_err   out  1  one-cycle strobe after a rejected load

module calendar_day_counter #(
    parameter int FEB_DAYS = 28
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic       load,
    input  logic [3:0] load_month,
    input  logic [4:0] load_day,
`ifdef CAL_LEAP_EN
    input  logic       leap,
`endif
    output logic [3:0] month,
    output logic [4:0] day,
    output logic       big_month,
    output logic       month_end,
    output logic       year_end,
    output logic       load_err
);

    // 31-day months; illegal month codes decode to 0.
    function automatic logic is_big_month(input logic [3:0] m);
        case (m)
            4'd1, 4'd3, 4'd5, 4'd7, 4'd8, 4'd10, 4'd12: is_big_month = 1'b1;
            default:                                    is_big_month = 1'b0;
        endcase
    endfunction

    function automatic logic [4:0] month_length(input logic [3:0] m, input logic [4:0] feb);
        if (is_big_month(m))
            month_length = 5'd31;
        else if (m == 4'd2)
            month_length = feb;
        else
            month_length = 5'd30;
    endfunction

    logic [4:0] feb_len;
    logic [4:0] cur_len;
    logic [4:0] load_len;
    logic [4:0] load_day_clamped;
    logic       load_month_ok;

`ifdef CAL_LEAP_EN
    assign feb_len = leap ? 5'd29 : 5'(FEB_DAYS);
`else
    assign feb_len = 5'(FEB_DAYS);
`endif

    assign big_month     = is_big_month(month);
    assign cur_len       = month_length(month, feb_len);
    assign load_len      = month_length(load_month, feb_len);
    assign load_month_ok = (load_month >= 4'd1) && (load_month <= 4'd12);

    always_comb begin
        load_day_clamped = load_day;
        if (load_day == 5'd0)
            load_day_clamped = 5'd1;
        else if (load_day > load_len)
            load_day_clamped = load_len;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            month     <= 4'd1;
            day       <= 5'd1;
            month_end <= 1'b0;
            year_end  <= 1'b0;
            load_err  <= 1'b0;
        end else begin
            month_end <= 1'b0;
            year_end  <= 1'b0;
            load_err  <= 1'b0;
            if (load) begin
                if (load_month_ok) begin
                    month <= load_month;
                    day   <= load_day_clamped;
                end else begin
                    load_err <= 1'b1;
                end
            end else if (tick) begin
                // A day beyond the month length can only appear if leap drops
                // while sitting on 2/29; treat it as the last day so the
                // counter rolls forward instead of running past the month.
                if (day < cur_len) begin
                    day <= day + 5'd1;
                end else begin
                    day       <= 5'd1;
                    month_end <= 1'b1;
                    if (month >= 4'd12) begin
                        month    <= 4'd1;
                        year_end <= 1'b1;
                    end else begin
                        month <= month + 4'd1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_calendar_day_counter.sv
// tb/tb_calendar_day_counter.sv - randomized self-checking bench for calendar_day_counter
module tb_calendar_day_counter;

    localparam int FEB = 28;

    logic       clk = 1'b0;
    logic       rst;
    logic       tick;
    logic       load;
    logic [3:0] load_month;
    logic [4:0] load_day;
    logic       leap_v;
    logic [3:0] month;
    logic [4:0] day;
    logic       big_month;
    logic       month_end;
    logic       year_end;
    logic       load_err;

    int checks   = 0;
    int failures = 0;

    // Reference state: calendar date plus the strobes the last cycle should raise.
    int  m_ref = 1;
    int  d_ref = 1;
    bit  me_ref, ye_ref, le_ref;
    int  lens [12] = '{31, 0, 31, 30, 31, 30, 31, 31, 30, 31, 30, 31};
`ifdef CAL_LEAP_EN
    localparam bit LEAP_BUILD = 1'b1;
`else
    localparam bit LEAP_BUILD = 1'b0;
`endif

    calendar_day_counter #(.FEB_DAYS(FEB)) dut (
        .clk        (clk),
        .rst        (rst),
        .tick       (tick),
        .load       (load),
        .load_month (load_month),
        .load_day   (load_day),
`ifdef CAL_LEAP_EN
        .leap       (leap_v),
`endif
        .month      (month),
        .day        (day),
        .big_month  (big_month),
        .month_end  (month_end),
        .year_end   (year_end),
        .load_err   (load_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (m_ref=%0d d_ref=%0d)", tag, got, exp, m_ref, d_ref);
        end
    endtask

    function automatic int days_in(input int mm, input bit lp);
        if (mm == 2) return (LEAP_BUILD && lp) ? 29 : FEB;
        return lens[mm-1];
    endfunction

    task automatic model(input bit r, input bit t, input bit l, input int lm, input int ld, input bit lp);
        int n;
        me_ref = 0; ye_ref = 0; le_ref = 0;
        if (r) begin
            m_ref = 1; d_ref = 1;
        end else if (l) begin
            if (lm >= 1 && lm <= 12) begin
                n     = days_in(lm, lp);
                m_ref = lm;
                d_ref = (ld < 1) ? 1 : (ld > n) ? n : ld;
            end else begin
                le_ref = 1;
            end
        end else if (t) begin
            n = days_in(m_ref, lp);
            if (d_ref < n) begin
                d_ref++;
            end else begin
                d_ref  = 1;
                me_ref = 1;
                if (m_ref == 12) begin
                    m_ref  = 1;
                    ye_ref = 1;
                end else begin
                    m_ref++;
                end
            end
        end
    endtask

    // Drive one cycle, advance the model on the edge, compare half a cycle later.
    task automatic step(input bit r, input bit t, input bit l, input int lm, input int ld);
        rst        = r;
        tick       = t;
        load       = l;
        load_month = lm[3:0];
        load_day   = ld[4:0];
        @(posedge clk);
        model(r, t, l, lm, ld, leap_v);
        @(negedge clk);
        check("month", int'(month), m_ref);
        check("day", int'(day), d_ref);
        check("big_month", int'(big_month), int'(days_in(m_ref, 1'b0) == 31));
        check("month_end", int'(month_end), int'(me_ref));
        check("year_end", int'(year_end), int'(ye_ref));
        check("load_err", int'(load_err), int'(le_ref));
    endtask

    initial begin
        int me_count;
        bit [11:0] bigs;
        rst = 1'b1; tick = 1'b0; load = 1'b0; load_month = '0; load_day = '0; leap_v = 1'b0;
        @(negedge clk);

        // Reset for two cycles, then idle.
        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        check("rst_month", int'(month), 1);
        check("rst_day", int'(day), 1);
        check("rst_big", int'(big_month), 1);

        // 31 ticks from 1/1 land on 2/1 with a single month_end.
        me_count = 0;
        for (int i = 0; i < 31; i++) begin
            step(0, 1, 0, 0, 0);
            me_count += int'(month_end);
        end
        check("jan_month", int'(month), 2);
        check("jan_day", int'(day), 1);
        check("jan_big", int'(big_month), 0);
        check("jan_me_last", int'(month_end), 1);
        check("jan_me_count", me_count, 1);
        step(0, 0, 0, 0, 0);
        check("jan_me_drop", int'(month_end), 0);

        // 4/30 rolls to 5/1; 4/31 clamps to 30; 0 clamps to 1.
        step(0, 0, 1, 4, 30);
        step(0, 1, 0, 0, 0);
        check("apr_roll_m", int'(month), 5);
        check("apr_roll_me", int'(month_end), 1);
        step(0, 0, 1, 4, 31);
        check("apr_clamp", int'(day), 30);
        step(0, 0, 1, 7, 0);
        check("zero_clamp", int'(day), 1);

        // Year rollover, then rejected loads leave the date alone.
        step(0, 0, 1, 12, 31);
        step(0, 1, 0, 0, 0);
        check("ye_month", int'(month), 1);
        check("ye_strobe", int'(year_end), 1);
        step(0, 1, 1, 13, 5);
        check("bad_load_err", int'(load_err), 1);
        check("bad_load_day", int'(day), 1);
        step(0, 0, 1, 0, 5);
        step(0, 0, 0, 0, 0);
        check("err_drop", int'(load_err), 0);

        // February.
        step(0, 0, 1, 2, 28);
        step(0, 1, 0, 0, 0);
        check("feb_roll", int'(month), 3);
`ifdef CAL_LEAP_EN
        leap_v = 1'b1;
        step(0, 0, 1, 2, 28);
        step(0, 1, 0, 0, 0);
        check("leap_29", int'(day), 29);
        step(0, 1, 0, 0, 0);
        check("leap_roll", int'(month), 3);
        step(0, 0, 1, 2, 31);
        check("leap_clamp", int'(day), 29);
        leap_v = 1'b0;
`endif

        // load beats tick; rst beats tick.
        step(0, 1, 1, 6, 10);
        check("load_wins_d", int'(day), 10);
        step(0, 1, 0, 0, 0);
        step(1, 1, 0, 0, 0);
        check("rst_mid_m", int'(month), 1);
        check("rst_mid_me", int'(month_end), 0);

        // big_month sweep.
        bigs = '0;
        for (int mm = 1; mm <= 12; mm++) begin
            step(0, 0, 1, mm, 15);
            bigs[mm-1] = big_month;
        end
        check("big_sweep", int'(bigs), int'(12'b1010_1101_0101));

        // Randomized run.
        for (int i = 0; i < 4000; i++) begin
            bit r, t, l;
            r = ($urandom_range(0, 199) == 0);
            l = ($urandom_range(0, 19) == 0);
            t = ($urandom_range(0, 9) != 0);
            if (LEAP_BUILD && $urandom_range(0, 99) == 0) leap_v = ~leap_v;
            step(r, t, l, int'($urandom_range(0, 15)), int'($urandom_range(0, 31)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
